bsg_piso_yumi: RTL and testbench
================================

BSG_PISO_YUMI -- requirements
Module: bsg_piso_yumi

Purpose: downstream consumer of a one-element valid/yumi FIFO. It takes one wide word and emits it as els_p narrow chunks on a valid/yumi interface, least-significant chunk first.

Interface
REQ-001 Parameter width_p, default 4: bit width of each output chunk.
REQ-002 Parameter els_p, default 4: number of chunks per input word; legal range is els_p >= 2.
REQ-003 Input word width SHALL be width_p*els_p, which is 16 at the defaults.
REQ-004 clk_i  input  1: the single clock; all state SHALL update on its rising edge.
REQ-005 reset_i  input  1: reset, synchronous and active-high.
REQ-006 valid_i  input  1: upstream word is valid; driven from the FIFO's v_o.
REQ-007 data_i  input  width_p*els_p: upstream word; driven from the FIFO's data_o.
REQ-008 yumi_o  output  1: word consumed this cycle; drives the FIFO's yumi_i.
REQ-009 valid_o  output  1: output chunk is valid.
REQ-010 data_o  output  width_p: current output chunk.
REQ-011 yumi_i  input  1: downstream consumes the current chunk this cycle.

Function
REQ-012 State machine SHALL have two states, EMPTY and BUSY, plus a chunk counter cnt of width $clog2(els_p) and a word register shift_r of width width_p*els_p.
REQ-013 valid_o SHALL equal (state == BUSY).
REQ-014 data_o SHALL equal shift_r[cnt*width_p +: width_p]; its value is unspecified when valid_o = 0.
REQ-015 EMPTY: yumi_o SHALL equal valid_i.
REQ-016 EMPTY, on valid_i: load shift_r <= data_i, set cnt <= 0, go to BUSY.
REQ-017 EMPTY, without valid_i: hold state.
REQ-018 BUSY with yumi_i and cnt < els_p-1: cnt <= cnt+1; yumi_o = 0.
REQ-019 BUSY with yumi_i, cnt == els_p-1 and valid_i (back-to-back): yumi_o = 1; load shift_r <= data_i; cnt <= 0; stay BUSY.
REQ-020 BUSY with yumi_i, cnt == els_p-1 and no valid_i: yumi_o = 0; cnt <= 0; go to EMPTY.
REQ-021 BUSY without yumi_i: hold state, cnt and shift_r; yumi_o = 0.
REQ-022 yumi_o SHALL never assert unless valid_i is high; it is combinational from valid_i, yumi_i, state and cnt.
REQ-023 Throughput SHALL be one word per els_p cycles under continuous valid_i and yumi_i, with no bubble between words.
REQ-024 Latency: the first chunk of a word accepted in cycle N SHALL appear on data_o with valid_o = 1 in cycle N+1.
REQ-025 No combinational path SHALL exist from data_i to data_o.
REQ-026 yumi_i asserted while valid_o = 0 is illegal; the simulation assertion SHALL flag it, and the block SHALL then ignore yumi_i.
REQ-027 The counter SHALL never exceed els_p-1; wrap to 0 occurs only per REQ-019 and REQ-020.

Reset
REQ-028 While reset_i = 1 at a rising edge: state <= EMPTY, cnt <= 0.
REQ-029 During a reset cycle, valid_o = 0 from the next cycle, and yumi_o SHALL be forced to 0 in that same cycle.
REQ-030 shift_r SHALL not be reset.
REQ-031 Reset mid-word SHALL discard the remaining chunks, and no partial word is resumed.
REQ-032 The first cycle after reset deasserts SHALL behave as EMPTY.

Verification (width_p=4, els_p=4)
REQ-033 Single word: reset, then valid_i=1 with data_i=16'hA5C3 for one cycle; yumi_i held at 1. Required: yumi_o=1 in that cycle; data_o = 3, C, 5, A on the next 4 cycles with valid_o=1; then valid_o=0.
REQ-034 Back-to-back: words 16'h1234 and 16'hBEEF presented continuously; yumi_i held at 1. Required: data_o = 4,3,2,1,F,E,E,B on 8 consecutive cycles; yumi_o=1 in the cycle the chunk 1 is consumed.
REQ-035 Backpressure: during word 16'hA5C3, drop yumi_i for 3 cycles while cnt=2. Required: data_o holds 5 with valid_o=1 and no chunk is lost or duplicated.
REQ-036 Reset mid-operation: assert reset_i while cnt=1 of 16'hA5C3. Required: valid_o=0 next cycle, yumi_o=0 during the reset cycle, and the next word starts from chunk 0.
REQ-037 Chained with the one-element FIFO and random valid_i/yumi_i over 10k cycles. Required: the scoreboard output stream equals the input words split LSB-first; yumi_o is never high without valid_i.

Source files
------------

// File: rtl/bsg_piso_yumi.sv
// bsg_piso_yumi: drains one wide word from a valid/yumi FIFO as els_p narrow chunks, LSB chunk first
module bsg_piso_yumi #(
   parameter int width_p = 4,
   parameter int els_p   = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       valid_i,
   input  logic [width_p*els_p-1:0]   data_i,
   output logic                       yumi_o,
   output logic                       valid_o,
   output logic [width_p-1:0]         data_o,
   input  logic                       yumi_i
);
   localparam int cnt_w = $clog2(els_p);
   typedef enum logic {EMPTY, BUSY} state_e;
   state_e                            state_r;
   logic [cnt_w-1:0]                  cnt_r;
   logic [els_p-1:0][width_p-1:0]     shift_r;
   logic                              last;
   assign last    = cnt_r == cnt_w'(els_p - 1);
   // a new word is taken when idle, or when the final chunk leaves, so words stream without a bubble
   assign yumi_o  = !reset_i && valid_i && (state_r == EMPTY || (yumi_i && last));
   assign valid_o = state_r == BUSY;
   assign data_o  = shift_r[cnt_r];
   always_ff @(posedge clk_i)
      if (reset_i) begin
         state_r <= EMPTY;
         cnt_r   <= '0;
      end else if (yumi_o) begin
         state_r <= BUSY;
         cnt_r   <= '0;
         shift_r <= data_i;
      end else if (state_r == BUSY && yumi_i) begin
         state_r <= last ? EMPTY : BUSY;
         cnt_r   <= last ? '0 : cnt_r + 1'b1;
      end
   a_no_yumi_when_idle: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !valid_o));
endmodule

// File: tb/tb_bsg_piso_yumi.sv
// tb_bsg_piso_yumi: directed scenarios plus a randomized FIFO-chained run against a chunk-stream scoreboard
module tb_bsg_piso_yumi;
   logic        clk = 0, reset_i = 1, valid_i = 0, yumi_i = 0;
   logic [15:0] data_i = '0;
   logic        yumi_o, valid_o;
   logic [3:0]  data_o;
   logic        o_yumi, o_valid;
   logic [3:0]  o_data;
   int          vecs = 0, errs = 0;

   bsg_piso_yumi #(.width_p(4), .els_p(4)) dut (
      .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
      .yumi_o(yumi_o), .valid_o(valid_o), .data_o(data_o), .yumi_i(yumi_i)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] chunk(input logic [15:0] w, input int i);
      return 4'(w >> (4 * i));
   endfunction

   // one cycle: inputs set after negedge, downstream ready only when a chunk is offered, outputs sampled before posedge
   task automatic drive(input logic v, input logic [15:0] d, input logic rdy, input logic rst);
      @(negedge clk);
      reset_i = rst;
      valid_i = v;
      data_i  = d;
      #1 yumi_i = rdy && valid_o;
      #1;
      o_yumi  = yumi_o;
      o_valid = valid_o;
      o_data  = data_o;
   endtask

   task automatic test_reset;
      drive(1, 16'hFFFF, 1, 1);
      vecs++;
      if (o_yumi !== 1'b0) begin errs++; $display("FAIL reset_yumi: got %b expected 0", o_yumi); end
      drive(1, 16'hFFFF, 1, 1);
      vecs++;
      if (o_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      drive(0, 16'h0, 1, 0);
      vecs++;
      if (o_valid !== 1'b0) begin errs++; $display("FAIL post_reset_valid: got %b expected 0", o_valid); end
   endtask

   task automatic test_single;
      logic [15:0] w = 16'hA5C3;
      drive(1, w, 1, 0);
      vecs++;
      if (o_yumi !== 1'b1 || o_valid !== 1'b0) begin
         errs++; $display("FAIL single_accept: got yumi=%b valid=%b expected yumi=1 valid=0", o_yumi, o_valid);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 16'h0, 1, 0);
         vecs++;
         if (o_valid !== 1'b1 || o_data !== chunk(w, i)) begin
            errs++; $display("FAIL single_chunk%0d: got valid=%b data=%h expected valid=1 data=%h", i, o_valid, o_data, chunk(w, i));
         end
      end
      drive(0, 16'h0, 1, 0);
      vecs++;
      if (o_valid !== 1'b0) begin errs++; $display("FAIL single_end: got valid=%b expected 0", o_valid); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] w [2] = '{16'h1234, 16'hBEEF};
      drive(1, w[0], 1, 0);
      vecs++;
      if (o_yumi !== 1'b1) begin errs++; $display("FAIL b2b_accept0: got %b expected 1", o_yumi); end
      for (int k = 0; k < 8; k++) begin
         drive(k < 4, w[1], 1, 0);
         vecs++;
         if (o_valid !== 1'b1 || o_data !== chunk(w[k/4], k % 4) || o_yumi !== (k == 3)) begin
            errs++;
            $display("FAIL b2b_cycle%0d: got valid=%b data=%h yumi=%b expected valid=1 data=%h yumi=%b",
                     k, o_valid, o_data, o_yumi, chunk(w[k/4], k % 4), k == 3);
         end
      end
      drive(0, 16'h0, 1, 0);
      vecs++;
      if (o_valid !== 1'b0) begin errs++; $display("FAIL b2b_end: got valid=%b expected 0", o_valid); end
   endtask

   task automatic test_backpressure;
      logic [15:0] w = 16'hA5C3;
      logic        rdy [7] = '{1, 1, 0, 0, 0, 1, 1};
      int          idx = 0;
      drive(1, w, 1, 0);
      for (int c = 0; c < 7; c++) begin
         drive(0, 16'h0, rdy[c], 0);
         vecs++;
         if (o_valid !== 1'b1 || o_data !== chunk(w, idx)) begin
            errs++; $display("FAIL bp_cycle%0d: got valid=%b data=%h expected valid=1 data=%h", c, o_valid, o_data, chunk(w, idx));
         end
         if (rdy[c]) idx++;
      end
      drive(0, 16'h0, 1, 0);
      vecs++;
      if (o_valid !== 1'b0) begin errs++; $display("FAIL bp_end: got valid=%b expected 0", o_valid); end
   endtask

   task automatic test_reset_mid;
      logic [15:0] w = 16'hA5C3, n = 16'h1234;
      drive(1, w, 1, 0);
      drive(0, 16'h0, 1, 0);
      drive(1, n, 1, 1);
      vecs++;
      if (o_yumi !== 1'b0 || o_data !== chunk(w, 1)) begin
         errs++; $display("FAIL midrst_cycle: got yumi=%b data=%h expected yumi=0 data=%h", o_yumi, o_data, chunk(w, 1));
      end
      drive(1, n, 1, 0);
      vecs++;
      if (o_valid !== 1'b0 || o_yumi !== 1'b1) begin
         errs++; $display("FAIL midrst_after: got valid=%b yumi=%b expected valid=0 yumi=1", o_valid, o_yumi);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 16'h0, 1, 0);
         vecs++;
         if (o_valid !== 1'b1 || o_data !== chunk(n, i)) begin
            errs++; $display("FAIL midrst_chunk%0d: got valid=%b data=%h expected valid=1 data=%h", i, o_valid, o_data, chunk(n, i));
         end
      end
      drive(0, 16'h0, 1, 0);
   endtask

   // one-element FIFO upstream; every enqueued word is split into the expected chunk stream
   task automatic test_random;
      logic        fifo_v = 0, fv0;
      logic [15:0] fifo_d = '0, w;
      logic [3:0]  exp_q [$];
      logic [3:0]  e;
      for (int c = 0; c < 10200; c++) begin
         drive(fifo_v, fifo_d, $urandom_range(0, 3) != 0, 0);
         vecs++;
         if (o_yumi && !valid_i) begin errs++; $display("FAIL rand_yumi_no_valid: cycle %0d got yumi=1 expected 0", c); end
         if (o_valid && yumi_i) begin
            vecs++;
            e = exp_q.size() ? exp_q.pop_front() : 4'hx;
            if (o_data !== e) begin errs++; $display("FAIL rand_stream: cycle %0d got %h expected %h", c, o_data, e); end
         end
         fv0 = fifo_v;
         if (o_yumi) fifo_v = 0;
         if (!fv0 && c < 10000 && $urandom_range(0, 2) != 0) begin
            w = 16'($urandom);
            fifo_v = 1;
            fifo_d = w;
            for (int i = 0; i < 4; i++) exp_q.push_back(chunk(w, i));
         end
      end
      vecs++;
      if (exp_q.size() != 0 || fifo_v || o_valid) begin
         errs++; $display("FAIL rand_drain: got %0d chunks left fifo_v=%b valid=%b expected 0", exp_q.size(), fifo_v, o_valid);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
